// File: rtl/alu_pkg.sv
// Shared ALU status definitions: flag bit positions, branch condition codes
// and the flags-reader FSM states.
package alu_pkg;

    localparam int FLAG_Z = 0;
    localparam int FLAG_S = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [3:0] {
        COND_EQ = 4'd0,
        COND_NE = 4'd1,
        COND_HS = 4'd2,
        COND_LO = 4'd3,
        COND_MI = 4'd4,
        COND_PL = 4'd5,
        COND_VS = 4'd6,
        COND_VC = 4'd7,
        COND_HI = 4'd8,
        COND_LS = 4'd9,
        COND_GE = 4'd10,
        COND_LT = 4'd11,
        COND_GT = 4'd12,
        COND_LE = 4'd13,
        COND_AL = 4'd14,
        COND_NV = 4'd15
    } cond_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational branch-condition evaluator: maps a condition code and the
// Z/S/C/V flags to a taken bit. Shared with the sequencer.
module cond_eval
    import alu_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [3:0] cond_code,
    output logic       taken
);

    logic z, s, c, v;

    assign z = flags[FLAG_Z];
    assign s = flags[FLAG_S];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        taken = 1'b0;
        case (cond_t'(cond_code))
            COND_EQ: taken = z;
            COND_NE: taken = !z;
            COND_HS: taken = c;
            COND_LO: taken = !c;
            COND_MI: taken = s;
            COND_PL: taken = !s;
            COND_VS: taken = v;
            COND_VC: taken = !v;
            COND_HI: taken = c && !z;
            COND_LS: taken = !c || z;
            COND_GE: taken = (s == v);
            COND_LT: taken = (s != v);
            COND_GT: taken = !z && (s == v);
            COND_LE: taken = z || (s != v);
            COND_AL: taken = 1'b1;
            COND_NV: taken = 1'b0;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_flags_reader.sv
// Latches ALU result/flags and answers branch-condition queries.
// Optional saturating V-flag counter is built when ALU_FLAGS_STICKY_EN is defined.
module alu_flags_reader
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flags_valid,
    input  logic [WIDTH-1:0] result,
    input  logic [3:0]       status_flags,
    input  logic             cond_req,
    input  logic [3:0]       cond_code,
    output logic             cond_ready,
    output logic             resp_valid,
    output logic             resp_taken,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] result_q,
    output logic [3:0]       flags_q,
    input  logic             sticky_clr,
    output logic [7:0]       ovf_count,
    output logic [1:0]       fsm_state
);

    state_t     state;
    logic [3:0] code_q;
    logic       taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            flags_q  <= '0;
        end else if (flags_valid) begin
            result_q <= result;
            flags_q  <= status_flags;
        end
    end

    cond_eval u_cond_eval (
        .flags     (flags_q),
        .cond_code (code_q),
        .taken     (taken)
    );

    // Handshakes: a query transfers on a rising edge where cond_req && cond_ready;
    // a response transfers on a rising edge where resp_valid && resp_ready, and
    // resp_taken is held unchanged from resp_valid rising until that transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            code_q     <= 4'd0;
            cond_ready <= 1'b1;
            resp_valid <= 1'b0;
            resp_taken <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cond_req) begin
                        code_q     <= cond_code;
                        cond_ready <= 1'b0;
                        state      <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    // flags_q is read before any write landing on this edge
                    resp_taken <= taken;
                    resp_valid <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        cond_ready <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    cond_ready <= 1'b1;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign fsm_state = state;

`ifdef ALU_FLAGS_STICKY_EN
    logic [7:0] ovf_cnt_q;

    // Clear has priority over a simultaneous overflow increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt_q <= 8'd0;
        end else if (sticky_clr) begin
            ovf_cnt_q <= 8'd0;
        end else if (flags_valid && status_flags[FLAG_V] && (ovf_cnt_q != 8'hFF)) begin
            ovf_cnt_q <= ovf_cnt_q + 8'd1;
        end
    end

    assign ovf_count = ovf_cnt_q;
`else
    logic unused_sticky_clr;

    assign unused_sticky_clr = sticky_clr;
    assign ovf_count         = 8'd0;
`endif

endmodule

// File: tb/tb_alu_flags_reader.sv
// Self-checking bench for alu_flags_reader: directed and random flag writes and
// branch queries against a behavioural model. Honours ALU_FLAGS_STICKY_EN.
module tb_alu_flags_reader;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             flags_valid;
    logic [WIDTH-1:0] result;
    logic [3:0]       status_flags;
    logic             cond_req;
    logic [3:0]       cond_code;
    logic             cond_ready;
    logic             resp_valid;
    logic             resp_taken;
    logic             resp_ready;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       flags_q;
    logic             sticky_clr;
    logic [7:0]       ovf_count;
    logic [1:0]       fsm_state;

    alu_flags_reader #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flags_valid  (flags_valid),
        .result       (result),
        .status_flags (status_flags),
        .cond_req     (cond_req),
        .cond_code    (cond_code),
        .cond_ready   (cond_ready),
        .resp_valid   (resp_valid),
        .resp_taken   (resp_taken),
        .resp_ready   (resp_ready),
        .result_q     (result_q),
        .flags_q      (flags_q),
        .sticky_clr   (sticky_clr),
        .ovf_count    (ovf_count),
        .fsm_state    (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    logic [WIDTH-1:0] result_m;
    logic [3:0]       flags_m;
    int               ovf_m;
    logic             exp_q[$];

    // Odd codes are the inverse of the even code before them; AL/NV share a pair.
    function automatic logic cond_ref(input logic [3:0] f, input logic [3:0] code);
        bit z = f[0];
        bit s = f[1];
        bit c = f[2];
        bit v = f[3];
        bit base;
        case (code >> 1)
            0: base = z;
            1: base = c;
            2: base = s;
            3: base = v;
            4: base = c && !z;
            5: base = (s == v);
            6: base = !z && (s == v);
            default: base = 1'b1;
        endcase
        return base ^ code[0];
    endfunction

    function automatic void model_write(input logic [WIDTH-1:0] r, input logic [3:0] f, input bit clr);
        result_m = r;
        flags_m  = f;
`ifdef ALU_FLAGS_STICKY_EN
        if (clr) ovf_m = 0;
        else if (f[3] && ovf_m < 255) ovf_m = ovf_m + 1;
`else
        if (clr) ovf_m = 0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver: one flag write, then check the status register and counter
    task automatic write_flags(input logic [WIDTH-1:0] r, input logic [3:0] f, input bit clr);
        flags_valid  = 1'b1;
        result       = r;
        status_flags = f;
        sticky_clr   = clr;
        tick();
        flags_valid = 1'b0;
        sticky_clr  = 1'b0;
        model_write(r, f, clr);
        check("result_q", 32'(result_q), 32'(result_m));
        check("flags_q", 32'(flags_q), 32'(flags_m));
        check("ovf_count", 32'(ovf_count), 32'(ovf_m));
    endtask

    // driver: one query with optional flag writes at accept, in EVAL, in RESP
    task automatic do_query(input logic [3:0] code, input int hold,
                            input bit wa, input logic [3:0] fa,
                            input bit we, input logic [3:0] fe,
                            input bit wr, input logic [3:0] fr);
        logic exp;
        logic [WIDTH-1:0] r;
        check("cond_ready_idle", 32'(cond_ready), 32'd1);
        r            = WIDTH'($urandom);
        cond_req     = 1'b1;
        cond_code    = code;
        flags_valid  = wa;
        result       = r;
        status_flags = fa;
        tick();
        if (wa) model_write(r, fa, 1'b0);
        exp_q.push_back(cond_ref(flags_m, code));
        cond_req    = 1'b0;
        flags_valid = we;
        status_flags = fe;
        resp_ready  = 1'b0;
        check("eval_resp_valid", 32'(resp_valid), 32'd0);
        check("eval_cond_ready", 32'(cond_ready), 32'd0);
        tick();
        if (we) model_write(r, fe, 1'b0);
        flags_valid = 1'b0;
        exp = exp_q.pop_front();
        check("resp_valid", 32'(resp_valid), 32'd1);
        check("resp_taken", 32'(resp_taken), 32'(exp));
        for (int i = 0; i < hold; i++) begin
            flags_valid  = wr && (i == 0);
            status_flags = fr;
            tick();
            if (wr && i == 0) model_write(r, fr, 1'b0);
            flags_valid = 1'b0;
            check("hold_resp_valid", 32'(resp_valid), 32'd1);
            check("hold_resp_taken", 32'(resp_taken), 32'(exp));
            check("hold_cond_ready", 32'(cond_ready), 32'd0);
        end
        resp_ready   = 1'b1;
        flags_valid  = wr && (hold == 0);
        status_flags = fr;
        tick();
        if (wr && hold == 0) model_write(r, fr, 1'b0);
        flags_valid = 1'b0;
        resp_ready  = 1'b0;
        check("done_resp_valid", 32'(resp_valid), 32'd0);
        check("done_cond_ready", 32'(cond_ready), 32'd1);
        check("done_flags_q", 32'(flags_q), 32'(flags_m));
    endtask

    initial begin
        rst_n        = 1'b0;
        flags_valid  = 1'b0;
        result       = '0;
        status_flags = '0;
        cond_req     = 1'b0;
        cond_code    = '0;
        resp_ready   = 1'b0;
        sticky_clr   = 1'b0;
        result_m     = '0;
        flags_m      = '0;
        ovf_m        = 0;

        #12;
        check("rst_cond_ready", 32'(cond_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_taken", 32'(resp_taken), 32'd0);
        check("rst_result_q", 32'(result_q), 32'd0);
        check("rst_flags_q", 32'(flags_q), 32'd0);
        check("rst_ovf_count", 32'(ovf_count), 32'd0);
        check("rst_state", 32'(fsm_state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_cond_ready", 32'(cond_ready), 32'd1);

        // Z set: EQ taken, NE not
        write_flags(8'h00, 4'b0001, 1'b0);
        do_query(4'd0, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0);
        do_query(4'd1, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0);

        // 5 - 7 = FE: S=1, C=0 (borrow), V=0
        write_flags(8'hFE, 4'b0010, 1'b0);
        do_query(4'd3, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0);
        check("sub_lo", 32'(resp_taken), 32'd1);
        do_query(4'd11, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0);
        do_query(4'd13, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0);
        do_query(4'd2, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0);
        check("sub_hs", 32'(resp_taken), 32'd0);
        do_query(4'd10, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0);
        do_query(4'd12, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0);

        // backpressure for 5 cycles
        do_query(4'd14, 5, 0, 4'h0, 0, 4'h0, 0, 4'h0);

        // V written on the accept edge, V cleared during RESP
        do_query(4'd6, 3, 1, 4'b1000, 0, 4'h0, 1, 4'b0000);
        check("vs_flags_after", 32'(flags_q), 32'd0);

        // write during EVAL: old flags (Z=1) decide EQ
        write_flags(8'h00, 4'b0001, 1'b0);
        do_query(4'd0, 1, 0, 4'h0, 1, 4'b0000, 0, 4'h0);

        // randomized queries with random side writes
        for (int i = 0; i < 40; i++) begin
            do_query(4'($urandom_range(0, 15)), $urandom_range(0, 3),
                     1'($urandom), 4'($urandom),
                     1'($urandom), 4'($urandom),
                     1'($urandom), 4'($urandom));
        end

        // overflow counter saturation and clear priority
        for (int i = 0; i < 260; i++) write_flags(8'($urandom), 4'b1000 | 4'($urandom_range(0, 7)), 1'b0);
`ifdef ALU_FLAGS_STICKY_EN
        check("ovf_saturated", 32'(ovf_count), 32'd255);
`else
        check("ovf_disabled", 32'(ovf_count), 32'd0);
`endif
        write_flags(8'h80, 4'b1000, 1'b1);
        check("ovf_clr_wins", 32'(ovf_count), 32'd0);
        write_flags(8'h81, 4'b1000, 1'b0);

        // reset during EVAL aborts the query immediately
        write_flags(8'h33, 4'b0101, 1'b0);
        cond_req  = 1'b1;
        cond_code = 4'd14;
        tick();
        cond_req = 1'b0;
        check("pre_rst_state_eval", 32'(fsm_state), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_flags_q", 32'(flags_q), 32'd0);
        check("async_rst_resp_valid", 32'(resp_valid), 32'd0);
        check("async_rst_state", 32'(fsm_state), 32'd0);
        check("async_rst_cond_ready", 32'(cond_ready), 32'd1);
        model_write('0, 4'h0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_abort_resp_valid", 32'(resp_valid), 32'd0);
        end
        check("post_abort_ovf", 32'(ovf_count), 32'(ovf_m));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
